// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the execute-stage multiply/divide unit.
package mdu_pkg;

    localparam int MDU_OP_W  = 4;
    localparam int MDU_CNT_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mult(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; kept separate so an iterative core can replace it.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    output logic [31:0]         hi_res,
    output logic [31:0]         lo_res,
    output logic                div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] quo;
    logic [31:0] rem;

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
    assign div_signed = (op == MDU_DIV);
    assign neg_a      = div_signed & a[31];
    assign neg_b      = div_signed & b[31];
    assign mag_a      = neg_a ? (~a + 32'd1) : a;
    assign mag_b      = neg_b ? (~b + 32'd1) : b;
    assign safe_b     = (b == 32'd0) ? 32'd1 : mag_b;
    assign quo        = mag_a / safe_b;
    assign rem        = mag_a % safe_b;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        div0   = 1'b0;
        case (op)
            MDU_MULT: begin
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                div0   = (b == 32'd0);
                lo_res = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
                hi_res = neg_a ? (~rem + 32'd1) : rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: latency counter, IDLE/RUN FSM, pending result and architectural HI/LO.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MDU_OP_W-1:0] MDU_op,
    input  logic [31:0]         MDU_A,
    input  logic [31:0]         MDU_B,
    output logic                MDU_start,
    output logic                MDU_busy,
    output logic                MDU_stall,
    output logic [31:0]         MDU_HI,
    output logic [31:0]         MDU_LO,
    output logic [31:0]         MDU_out
);

    localparam logic [MDU_CNT_W-1:0] MULT_LAST = MDU_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MDU_CNT_W-1:0] DIV_LAST  = MDU_CNT_W'(DIV_CYCLES - 1);

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          pend_hi_q, pend_hi_d;
    logic [31:0]          pend_lo_q, pend_lo_d;
    logic                 pend_div0_q, pend_div0_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;

    logic [31:0]          hi_res;
    logic [31:0]          lo_res;
    logic                 div0;

    mdu_arith u_arith (
        .op     (MDU_op),
        .a      (MDU_A),
        .b      (MDU_B),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    assign MDU_busy  = (state_q == ST_RUN);
    assign MDU_start = is_muldiv(MDU_op) && !MDU_busy && reset;
    assign MDU_stall = MDU_start | MDU_busy;
    assign MDU_HI    = hi_q;
    assign MDU_LO    = lo_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (MDU_start) begin
                    state_d     = ST_RUN;
                    cnt_d       = is_mult(MDU_op) ? MULT_LAST : DIV_LAST;
                    pend_hi_d   = hi_res;
                    pend_lo_d   = lo_res;
                    pend_div0_d = div0;
                end else if (MDU_op == MDU_MTHI) begin
                    hi_d = MDU_A;
                end else if (MDU_op == MDU_MTLO) begin
                    lo_d = MDU_A;
                end
            end
            ST_RUN: begin
                // New ops are ignored here; an in-flight op is never cancelled by a stall.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (!pend_div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_div0_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    always_comb begin
        case (MDU_op)
            MDU_MFHI: MDU_out = hi_q;
            MDU_MFLO: MDU_out = lo_q;
            default:  MDU_out = 32'd0;
        endcase
    end

endmodule
